// File: rtl/vv_defs.sv
// Shared constants for the CPU-to-RAM access path: word/address widths,
// responder FSM encoding and the halt instruction word.
package vv_defs;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [DATA_W-1:0] HLT_WORD = 10'b000_1111111;

endpackage

// File: rtl/vvmem_array.sv
// Single-port synchronous word RAM. The one address port is shared by the CPU
// path and the loader; src_sel_i picks which side supplies address and write data.
module vvmem_array #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              src_sel_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [DATA_W-1:0] rdata_q;

    assign addr     = src_sel_i ? ld_addr_i : cpu_addr_i;
    assign wdata    = src_sel_i ? ld_data_i : cpu_wdata_i;
    assign idx      = addr[IDX_W-1:0];
    // Addresses past DEPTH alias onto low words once truncated, so gate on the full address.
    assign in_range = (32'(addr) < DEPTH_U);

    always_ff @(posedge clk_i) begin
        if (wr_en_i && in_range) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= in_range ? mem[idx] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vvmem_responder.sv
// Memory responder for the CPU access path: four-phase REQ/ACK handshake with
// programmable wait states, plus a loader port that writes only while idle.
module vvmem_responder #(
    parameter int DATA_W      = vv_defs::DATA_W,
    parameter int ADDR_W      = vv_defs::ADDR_W,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              BUSY,
    input  logic              LD_VALID,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_READY
);

    import vv_defs::*;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              ld_fire;
    logic              mem_wr_en;
    logic              mem_rd_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    addr_d  = ADDR;
                    we_d    = WE;
                    wdata_d = WDATA;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ack_d   = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A REQ that dropped early is already low here, giving a one-cycle ACK.
                if (!REQ) begin
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // CPU has priority in IDLE; loader and CPU accesses never share a cycle.
    assign LD_READY  = (state_q == S_IDLE) && !REQ;
    assign ld_fire   = LD_VALID && LD_READY;
    assign mem_wr_en = ((state_q == S_RESP) && we_q) || ld_fire;
    assign mem_rd_en = (state_q == S_RESP) && !we_q;

    vvmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .wr_en_i     (mem_wr_en),
        .rd_en_i     (mem_rd_en),
        .src_sel_i   (ld_fire),
        .cpu_addr_i  (addr_q),
        .cpu_wdata_i (wdata_q),
        .ld_addr_i   (LD_ADDR),
        .ld_data_i   (LD_DATA),
        .rdata_o     (RDATA)
    );

    assign ACK  = ack_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_vvmem_responder.sv
// Directed bench: three responders (1 wait state, 0 wait states, 3 wait states
// with 64 words) driven through loader preloads, handshakes and a mid-access reset.
module tb_vvmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n    [3];
    logic       req      [3];
    logic       we       [3];
    logic [6:0] addr     [3];
    logic [9:0] wdata    [3];
    logic       ld_valid [3];
    logic [6:0] ld_addr  [3];
    logic [9:0] ld_data  [3];

    logic [9:0] rdata_a, rdata_b, rdata_c;
    logic       ack_a, ack_b, ack_c;
    logic       busy_a, busy_b, busy_c;
    logic       ldr_a, ldr_b, ldr_c;

    int checks = 0;
    int errors = 0;

    vvmem_responder #(.WAIT_CYCLES(1), .DEPTH(128)) u_a (
        .CLK(clk), .RST_N(rst_n[0]), .REQ(req[0]), .WE(we[0]), .ADDR(addr[0]),
        .WDATA(wdata[0]), .RDATA(rdata_a), .ACK(ack_a), .BUSY(busy_a),
        .LD_VALID(ld_valid[0]), .LD_ADDR(ld_addr[0]), .LD_DATA(ld_data[0]), .LD_READY(ldr_a)
    );

    vvmem_responder #(.WAIT_CYCLES(0), .DEPTH(128)) u_b (
        .CLK(clk), .RST_N(rst_n[1]), .REQ(req[1]), .WE(we[1]), .ADDR(addr[1]),
        .WDATA(wdata[1]), .RDATA(rdata_b), .ACK(ack_b), .BUSY(busy_b),
        .LD_VALID(ld_valid[1]), .LD_ADDR(ld_addr[1]), .LD_DATA(ld_data[1]), .LD_READY(ldr_b)
    );

    vvmem_responder #(.WAIT_CYCLES(3), .DEPTH(64)) u_c (
        .CLK(clk), .RST_N(rst_n[2]), .REQ(req[2]), .WE(we[2]), .ADDR(addr[2]),
        .WDATA(wdata[2]), .RDATA(rdata_c), .ACK(ack_c), .BUSY(busy_c),
        .LD_VALID(ld_valid[2]), .LD_ADDR(ld_addr[2]), .LD_DATA(ld_data[2]), .LD_READY(ldr_c)
    );

    function automatic logic [9:0] f_rdata(input int k);
        case (k)
            0:       return rdata_a;
            1:       return rdata_b;
            default: return rdata_c;
        endcase
    endfunction

    function automatic logic f_ack(input int k);
        case (k)
            0:       return ack_a;
            1:       return ack_b;
            default: return ack_c;
        endcase
    endfunction

    function automatic logic f_busy(input int k);
        case (k)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic f_ldr(input int k);
        case (k)
            0:       return ldr_a;
            1:       return ldr_b;
            default: return ldr_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One loader write; LD_READY must be high on the accepting cycle.
    task automatic load(input int k, input logic [6:0] a, input logic [9:0] d, input string tag);
        ld_valid[k] = 1'b1;
        ld_addr[k]  = a;
        ld_data[k]  = d;
        #1;
        chk({tag, "_ldready"}, 10'(f_ldr(k)), 10'd1);
        tick();
        ld_valid[k] = 1'b0;
        $display("load   dut=%0d addr=%h data=%h", k, a, d);
    endtask

    // Full handshake; request fields are scrambled after capture to confirm they are latched.
    task automatic access(input int k, input logic w, input logic [6:0] a, input logic [9:0] d,
                          input int waits, input logic [9:0] exp_rd, input string tag);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        tick();
        chk({tag, "_busy_cap"}, 10'(f_busy(k)), 10'd1);
        we[k]    = ~w;
        addr[k]  = ~a;
        wdata[k] = ~d;
        chk({tag, "_ack_early"}, 10'(f_ack(k)), 10'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({tag, "_ack_wait"}, 10'(f_ack(k)), 10'd0);
        end
        tick();
        chk({tag, "_ack_rise"}, 10'(f_ack(k)), 10'd1);
        chk({tag, "_rdata"}, f_rdata(k), exp_rd);
        req[k] = 1'b0;
        we[k]  = 1'b0;
        #1;
        chk({tag, "_ack_hold"}, 10'(f_ack(k)), 10'd1);
        tick();
        chk({tag, "_ack_fall"}, 10'(f_ack(k)), 10'd0);
        chk({tag, "_busy_fall"}, 10'(f_busy(k)), 10'd0);
        $display("access dut=%0d we=%0d addr=%h wdata=%h rdata=%h", k, w, a, d, f_rdata(k));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
            wdata[k] = '0; ld_valid[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", 10'(f_ack(k)), 10'd0);
            chk("rst_busy", 10'(f_busy(k)), 10'd0);
            chk("rst_rdata", f_rdata(k), 10'h000);
        end
        tick();

        // One wait state: loader preload, reads, write/readback.
        load(0, 7'h7E, 10'h003, "a_ld7e");
        load(0, 7'h7F, 10'h004, "a_ld7f");
        access(0, 1'b0, 7'h7E, 10'h000, 1, 10'h003, "a_rd7e");
        access(0, 1'b1, 7'h7D, 10'h007, 1, 10'h003, "a_wr7d");
        access(0, 1'b0, 7'h7D, 10'h000, 1, 10'h007, "a_rd7d");
        access(0, 1'b0, 7'h7F, 10'h000, 1, 10'h004, "a_rd7f");

        // CPU and loader contend in IDLE: CPU wins and reads the old word.
        ld_valid[0] = 1'b1;
        ld_addr[0]  = 7'h7E;
        ld_data[0]  = 10'h111;
        req[0]      = 1'b1;
        addr[0]     = 7'h7E;
        #1;
        chk("a_contend_ldready", 10'(ldr_a), 10'd0);
        access(0, 1'b0, 7'h7E, 10'h000, 1, 10'h003, "a_contend");
        chk("a_after_ldready", 10'(ldr_a), 10'd1);
        tick();
        ld_valid[0] = 1'b0;
        access(0, 1'b0, 7'h7E, 10'h000, 1, 10'h111, "a_rd7e_ld");

        // Zero wait states.
        load(1, 7'h00, 10'b1001111111, "b_ld00");
        access(1, 1'b0, 7'h00, 10'h000, 0, 10'b1001111111, "b_rd00");
        access(1, 1'b1, 7'h01, vv_defs::HLT_WORD, 0, 10'b1001111111, "b_wr01");
        access(1, 1'b0, 7'h01, 10'h000, 0, vv_defs::HLT_WORD, "b_rd01");

        // Three wait states, 64 words.
        load(2, 7'h10, 10'h0AB, "c_ld10");
        access(2, 1'b0, 7'h10, 10'h000, 3, 10'h0AB, "c_rd10");
        access(2, 1'b1, 7'h50, 10'h3C3, 3, 10'h0AB, "c_wr50");
        access(2, 1'b0, 7'h10, 10'h000, 3, 10'h0AB, "c_rd10_alias");

        // Reset during WAIT of a write: outputs clear at once, memory keeps old word.
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 7'h10; wdata[2] = 10'h155;
        tick();
        tick();
        chk("c_busy_prerst", 10'(busy_c), 10'd1);
        rst_n[2] = 1'b0;
        #1;
        chk("c_rst_ack", 10'(ack_c), 10'd0);
        chk("c_rst_busy", 10'(busy_c), 10'd0);
        chk("c_rst_rdata", rdata_c, 10'h000);
        $display("reset  dut=2 during WAIT of write addr=10 data=155");
        req[2] = 1'b0; we[2] = 1'b0;
        tick();
        rst_n[2] = 1'b1;
        tick();
        access(2, 1'b0, 7'h10, 10'h000, 3, 10'h0AB, "c_rd10_postrst");

        // Single-cycle REQ pulse to an out-of-range address.
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 7'h50;
        tick();
        req[2] = 1'b0;
        chk("c_pulse_busy", 10'(busy_c), 10'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_pulse_ack_wait", 10'(ack_c), 10'd0);
        end
        tick();
        chk("c_pulse_ack", 10'(ack_c), 10'd1);
        chk("c_pulse_rdata", rdata_c, 10'h000);
        tick();
        chk("c_pulse_ack_fall", 10'(ack_c), 10'd0);
        chk("c_pulse_busy_fall", 10'(busy_c), 10'd0);
        chk("c_pulse_idle", 10'(ldr_c), 10'd1);
        $display("access dut=2 req pulse addr=50 rdata=%h", rdata_c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vvmem_responder.md
Name: vvmem_responder

Overview:
Memory responder (slave) end of the CPU-to-RAM access path. It holds 128 x 10-bit words and serves instruction fetch, LD_A/LD_B reads and STR_A writes. Each access uses a four-phase REQ/ACK handshake with a configurable number of wait states. A secondary loader port preloads program and data words before the CPU runs.

Parameters:
DATA_W, 10, word width (matches 10-bit instruction/data format)
ADDR_W, 7, address width
DEPTH, 128, implemented words; must be <= 2**ADDR_W
WAIT_CYCLES, 1, wait states between request capture and response (0..15)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ  in  1  CPU access request, held high until ACK seen
WE  in  1  1 = write (STR_A), 0 = read (fetch/LD_A/LD_B)
ADDR  in  ADDR_W  access address
WDATA  in  DATA_W  write data
RDATA  out  DATA_W  read data, valid while ACK=1
ACK  out  1  response; held high until REQ falls
BUSY  out  1  high from capture until handshake completion
LD_VALID  in  1  loader write strobe
LD_ADDR  in  ADDR_W  loader address
LD_DATA  in  DATA_W  loader data
LD_READY  out  1  loader write accepted this cycle when LD_VALID=1

Behaviour:
- Reset (RST_N=0, async): state=IDLE, RDATA=0, ACK=0, BUSY=0, wait counter=0, captured registers=0. Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE, REQ=1: capture ADDR/WE/WDATA, set BUSY=1, load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0; otherwise go to RESP.
- WAIT: decrement counter each cycle. When counter reaches 1, go to RESP.
- RESP (single cycle): perform the access.
  - Write: mem[addr] <= wdata; RDATA unchanged.
  - Read: RDATA <= mem[addr].
  - Registered ACK=1 from the next cycle. Go to HOLD.
- HOLD: ACK=1, BUSY=1 while REQ=1. When REQ=0, next cycle ACK=0, BUSY=0, state=IDLE.
- Latency: REQ high at edge N gives ACK high after edge N+WAIT_CYCLES+1. Minimum: 1 cycle with zero wait states.
- RDATA holds its last read value until the next read completes.
- Address range: ADDR >= DEPTH reads 0; writes to it are ignored. ACK still given.
- REQ dropped before ACK (protocol violation): transaction still completes and ACK pulses for exactly one cycle, because REQ is already low in HOLD.
- ADDR/WE/WDATA changes after capture are ignored.
- Loader port:
  - LD_READY = (state==IDLE) && !REQ, combinational.
  - When LD_VALID && LD_READY: mem[LD_ADDR] <= LD_DATA on that edge. Out-of-range addresses are ignored.
  - If REQ and LD_VALID are both high in IDLE, the CPU wins; the loader must hold LD_VALID.
- Reset mid-operation: a pending write that has not reached RESP is dropped and memory is unchanged. ACK drops immediately.
- Back-to-back: a new REQ is only captured in IDLE, i.e. at least one cycle after ACK falls.

Decomposition:
- Shared package (vv_defs):
  - DATA_W and ADDR_W constants.
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2, HOLD=2'd3.
  - HLT word constant (10'b000_1111111) for benches.
- One natural sub-module, vvmem_array: a DEPTH x DATA_W single-port synchronous RAM with a write-enable and mux-selected write source (CPU or loader).
- Handshake FSM and wait counter stay in the top module.

Test Plan:
- Loader writes 10'h003 to 7'h7E and 10'h004 to 7'h7F with REQ=0. LD_READY=1 on both cycles. CPU read of 7'h7E with WAIT_CYCLES=1 -> ACK rises 2 edges after REQ, RDATA=10'h003.
- Write 10'h007 to 7'h7D via REQ/WE=1, then read 7'h7D -> RDATA=10'h007. BUSY covers both transactions. ACK falls the cycle after REQ falls.
- WAIT_CYCLES=0: read 7'h00 preloaded with 10'b1001111111 -> ACK high after 1 edge, RDATA=10'b1001111111.
- REQ and LD_VALID high together in IDLE -> CPU captured, LD_READY=0. The loader write lands only after the handshake completes and LD_READY returns to 1.
- Write 10'h155 to 7'h10 with WAIT_CYCLES=3; assert RST_N=0 during WAIT. Outputs go to 0 immediately; a subsequent read of 7'h10 returns the prior contents, not 10'h155.
- REQ pulsed for 1 cycle only -> ACK asserted for exactly one cycle, then IDLE. With DEPTH=64, a read of 7'h50 returns 0.
